// File: rtl/risc_spm_core_gen.sv
`default_nettype none
// ============================================================================
// Module   : risc_spm_core_gen
// Purpose  : Multi-cycle RISC core for the simple programmable machine (SPM).
//            It has a parametrised register file and one unified program/data
//            memory reached through a req/ready handshake, so the memory may
//            insert wait states.
// Option   : RISC_SPM_CARRY_EN adds the carry flag (cflag port) and the BRC
//            instruction. Without it, opcode 9 traps as illegal.
// Revision : 1.0 - initial parametrised generation
// ============================================================================
module risc_spm_core_gen #(
  parameter int WORD_W   = 8,
  parameter int REG_AW   = 2,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [WORD_W-1:0] pc_out,
  output logic              zflag,
  output logic              halted,
  output logic              illegal_op
`ifdef RISC_SPM_CARRY_EN
  ,
  output logic              cflag
`endif
);

  localparam int          c_NREG     = 1 << REG_AW;
  localparam logic [WORD_W-1:0] c_RESET_PC = WORD_W'(RESET_PC);

  localparam logic [3:0] c_OP_NOP  = 4'd0;
  localparam logic [3:0] c_OP_ADD  = 4'd1;
  localparam logic [3:0] c_OP_SUB  = 4'd2;
  localparam logic [3:0] c_OP_AND  = 4'd3;
  localparam logic [3:0] c_OP_NOT  = 4'd4;
  localparam logic [3:0] c_OP_RD   = 4'd5;
  localparam logic [3:0] c_OP_WR   = 4'd6;
  localparam logic [3:0] c_OP_BR   = 4'd7;
  localparam logic [3:0] c_OP_BRZ  = 4'd8;
`ifdef RISC_SPM_CARRY_EN
  localparam logic [3:0] c_OP_BRC  = 4'd9;
`endif
  localparam logic [3:0] c_OP_HALT = 4'd15;

  // The opcode and both register fields must fit in one instruction word.
  generate
    if (WORD_W < 4 + 2 * REG_AW) begin : g_bad_width
      $error("risc_spm_core_gen: WORD_W must be >= 4 + 2*REG_AW");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DEC   = 3'd2,
    S_EX    = 3'd3,
    S_OPA   = 3'd4,
    S_MEM   = 3'd5,
    S_HALT  = 3'd6
  } state_t;

  state_t            r_state;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_ir;
  logic [WORD_W-1:0] r_ar;
  logic [WORD_W-1:0] r_regs [c_NREG];
`ifdef RISC_SPM_CARRY_EN
  logic              r_c;
`endif

  logic [3:0]        w_op;
  logic [REG_AW-1:0] w_src;
  logic [REG_AW-1:0] w_dst;
  logic [WORD_W-1:0] w_src_val;
  logic [WORD_W-1:0] w_dst_val;
  logic [WORD_W-1:0] w_pc_inc;
  logic [WORD_W-1:0] w_alu_res;
`ifdef RISC_SPM_CARRY_EN
  logic              w_alu_c;
`endif
  logic              w_done;
  logic              w_is_alu;
  logic              w_is_ldst;
  logic              w_is_cbr;
  logic              w_cond;

  assign w_op      = r_ir[WORD_W-1 -: 4];
  assign w_src     = r_ir[2*REG_AW-1 -: REG_AW];
  assign w_dst     = r_ir[REG_AW-1:0];
  assign w_src_val = r_regs[w_src];
  assign w_dst_val = r_regs[w_dst];
  assign w_pc_inc  = r_pc + WORD_W'(1);
  assign w_done    = mem_req & mem_ready;
  assign w_is_alu  = (w_op == c_OP_ADD) || (w_op == c_OP_SUB) ||
                     (w_op == c_OP_AND) || (w_op == c_OP_NOT);
  assign w_is_ldst = (w_op == c_OP_RD) || (w_op == c_OP_WR);
  assign pc_out    = r_pc;

`ifdef RISC_SPM_CARRY_EN
  assign w_is_cbr  = (w_op == c_OP_BRZ) || (w_op == c_OP_BRC);
  assign w_cond    = (w_op == c_OP_BRC) ? r_c : zflag;
  assign cflag     = r_c;
`else
  assign w_is_cbr  = (w_op == c_OP_BRZ);
  assign w_cond    = zflag;
`endif

  // ALU result for the instruction held in IR; the SUB borrow is the sign of the widened difference
  always_comb begin
    w_alu_res = '0;
`ifdef RISC_SPM_CARRY_EN
    w_alu_c   = 1'b0;
`endif
    case (w_op)
`ifdef RISC_SPM_CARRY_EN
      c_OP_ADD: {w_alu_c, w_alu_res} = {1'b0, w_dst_val} + {1'b0, w_src_val};
      c_OP_SUB: {w_alu_c, w_alu_res} = {1'b0, w_dst_val} - {1'b0, w_src_val};
`else
      c_OP_ADD: w_alu_res = w_dst_val + w_src_val;
      c_OP_SUB: w_alu_res = w_dst_val - w_src_val;
`endif
      c_OP_AND: w_alu_res = w_dst_val & w_src_val;
      c_OP_NOT: w_alu_res = ~w_src_val;
      default:  w_alu_res = '0;
    endcase
  end

  // Control FSM, datapath registers and registered bus outputs; the bus drops at once on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pc       <= c_RESET_PC;
      r_ir       <= '0;
      r_ar       <= '0;
      zflag      <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      halted     <= 1'b0;
      illegal_op <= 1'b0;
      for (int i = 0; i < c_NREG; i++) r_regs[i] <= '0;
`ifdef RISC_SPM_CARRY_EN
      r_c        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= r_pc;
          r_state  <= S_FETCH;
        end

        S_FETCH: begin
          if (w_done) begin
            r_ir    <= mem_rdata;
            r_pc    <= w_pc_inc;
            mem_req <= 1'b0;
            r_state <= S_DEC;
          end
        end

        S_DEC: begin
          if (w_op == c_OP_NOP) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= r_pc;
            r_state  <= S_FETCH;
          end else if (w_is_alu) begin
            r_state  <= S_EX;
          end else if (w_is_ldst || (w_op == c_OP_BR) || (w_is_cbr && w_cond)) begin
            // operand word sits at the already-incremented PC
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= r_pc;
            r_state  <= S_OPA;
          end else if (w_is_cbr) begin
            // branch not taken: skip the operand without reading it
            r_pc     <= w_pc_inc;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= w_pc_inc;
            r_state  <= S_FETCH;
          end else if (w_op == c_OP_HALT) begin
            halted   <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            illegal_op <= 1'b1;
            halted     <= 1'b1;
            r_state    <= S_HALT;
          end
        end

        S_EX: begin
          r_regs[w_dst] <= w_alu_res;
          zflag         <= (w_alu_res == '0);
`ifdef RISC_SPM_CARRY_EN
          if ((w_op == c_OP_ADD) || (w_op == c_OP_SUB)) r_c <= w_alu_c;
`endif
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= r_pc;
          r_state  <= S_FETCH;
        end

        S_OPA: begin
          if (w_done) begin
            r_ar <= mem_rdata;
            if (w_is_ldst) begin
              r_pc     <= w_pc_inc;
              mem_addr <= mem_rdata;
              mem_we   <= (w_op == c_OP_WR);
              if (w_op == c_OP_WR) mem_wdata <= w_src_val;
              r_state  <= S_MEM;
            end else begin
              r_pc     <= mem_rdata;
              mem_addr <= mem_rdata;
              mem_we   <= 1'b0;
              r_state  <= S_FETCH;
            end
          end
        end

        S_MEM: begin
          if (w_done) begin
            if (w_op == c_OP_RD) r_regs[w_dst] <= mem_rdata;
            mem_we   <= 1'b0;
            mem_addr <= r_pc;
            r_state  <= S_FETCH;
          end else begin
            // AR is the authoritative data address while the transfer waits
            mem_addr <= r_ar;
          end
        end

        S_HALT: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          halted  <= 1'b1;
        end

        default: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_risc_spm_core_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc_spm_core_gen
// Purpose  : Scoreboard bench for risc_spm_core_gen. An instruction-level
//            reference model predicts every bus transfer and the final
//            architectural state. A monitor pops and compares each transfer
//            as the core completes it.
// Option   : honours RISC_SPM_CARRY_EN (cflag port, BRC opcode)
// Revision : 1.0 - initial bench
// ============================================================================
module tb_risc_spm_core_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mem_req, mem_we, mem_ready = 1'b0;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic       zflag, halted, illegal_op;
`ifdef RISC_SPM_CARRY_EN
  logic       cflag;
`endif

  always #5 clk = ~clk;

  risc_spm_core_gen #(.WORD_W(8), .REG_AW(2), .RESET_PC(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .pc_out     (pc_out),
    .zflag      (zflag),
    .halted     (halted),
    .illegal_op (illegal_op)
`ifdef RISC_SPM_CARRY_EN
    ,
    .cflag      (cflag)
`endif
  );

  typedef struct packed {
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
  } txn_t;

  txn_t       exp_q [$];
  logic [7:0] mem       [256];
  logic [7:0] img       [256];
  logic [7:0] model_mem [256];
  int         n_cmp = 0;
  int         n_fail = 0;
  bit         load_pulse = 1'b0;
  int         rdy_mode = 0;
  int         rdy_waits = 0;
  int         wcnt = 0;
  int         cyc_cnt = 0;
  int         halt_cyc = 0;
  logic [7:0] exp_pc;
  logic       exp_z, exp_c, exp_ill;
  int         exp_cyc;
  bit         model_ok;
  txn_t       snap;
  bit         hold_pend = 1'b0;

  assign mem_rdata = mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_txn(input logic [7:0] a, input logic w, input logic [7:0] d);
    txn_t t;
    t.addr = a; t.we = w; t.wdata = d;
    exp_q.push_back(t);
  endfunction

  // memory model: image load, or commit of a completing write
  always @(posedge clk) begin
    if (load_pulse) begin
      for (int a = 0; a < 256; a++) mem[a] = img[a];
    end else if (rst && mem_req && mem_ready && mem_we) begin
      mem[mem_addr] = mem_wdata;
    end
  end

  // ready generator: fixed wait states per transfer, or random
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) begin
      mem_ready = 1'($urandom_range(0, 1));
    end else if (!mem_req) begin
      mem_ready = 1'b0;
      wcnt = 0;
    end else if (wcnt < rdy_waits) begin
      mem_ready = 1'b0;
      wcnt++;
    end else begin
      mem_ready = 1'b1;
      wcnt = 0;
    end
  end

  // cycles since reset release
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc_cnt = 0;
    else      cyc_cnt = cyc_cnt + 1;
  end

  // monitor: stability during waits, scoreboard pop on each completion
  always @(negedge clk) begin
    if (!rst) begin
      hold_pend = 1'b0;
      halt_cyc  = 0;
    end else begin
      if (halted && halt_cyc == 0) halt_cyc = cyc_cnt;
      if (hold_pend && mem_req)
        check("hold", {15'd0, mem_addr, mem_we, mem_wdata}, {15'd0, snap.addr, snap.we, snap.wdata});
      if (mem_req && mem_ready) begin
        hold_pend = 1'b0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_txn: addr %0h we %0b, required no transfer", mem_addr, mem_we);
        end else begin
          txn_t e;
          e = exp_q.pop_front();
          check("txn_addr", mem_addr, e.addr);
          check("txn_we", mem_we, e.we);
          if (e.we) check("txn_wdata", mem_wdata, e.wdata);
        end
      end else if (mem_req) begin
        hold_pend  = 1'b1;
        snap.addr  = mem_addr;
        snap.we    = mem_we;
        snap.wdata = mem_wdata;
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  // instruction-level reference model over a private copy of img
  task automatic model_run(input int waits);
    logic [7:0] m [256];
    logic [7:0] r [4];
    logic [7:0] pc, ir, opnd;
    logic [8:0] wide;
    logic [3:0] op;
    logic [1:0] s, d;
    logic       z, c, ill, tk;
    int         lat, nx, steps;
    bit         done;
    m = img;
    for (int i = 0; i < 4; i++) r[i] = 8'h00;
    pc = 8'h00; z = 1'b0; c = 1'b0; ill = 1'b0; done = 1'b0; steps = 0;
    exp_q.delete();
    exp_cyc = 1;
    while (!done && steps < 150) begin
      steps++;
      push_txn(pc, 1'b0, 8'h00);
      ir = m[pc]; pc = pc + 8'd1; nx = 1; lat = 2; tk = 1'b0;
      op = ir[7:4]; s = ir[3:2]; d = ir[1:0];
      case (op)
        4'd0: lat = 2;
        4'd1: begin wide = {1'b0, r[d]} + {1'b0, r[s]}; r[d] = wide[7:0]; c = wide[8]; z = (r[d] == 0); lat = 3; end
        4'd2: begin c = (r[d] < r[s]); r[d] = r[d] - r[s]; z = (r[d] == 0); lat = 3; end
        4'd3: begin r[d] = r[d] & r[s]; z = (r[d] == 0); lat = 3; end
        4'd4: begin r[d] = ~r[s]; z = (r[d] == 0); lat = 3; end
        4'd5: begin opnd = m[pc]; push_txn(pc, 1'b0, 8'h00); pc = pc + 8'd1;
                    push_txn(opnd, 1'b0, 8'h00); r[d] = m[opnd]; nx = 3; lat = 4; end
        4'd6: begin opnd = m[pc]; push_txn(pc, 1'b0, 8'h00); pc = pc + 8'd1;
                    push_txn(opnd, 1'b1, r[s]); m[opnd] = r[s]; nx = 3; lat = 4; end
        4'd7: tk = 1'b1;
        4'd8: begin tk = z; if (!z) pc = pc + 8'd1; end
`ifdef RISC_SPM_CARRY_EN
        4'd9: begin tk = c; if (!c) pc = pc + 8'd1; end
`endif
        4'd15: done = 1'b1;
        default: begin ill = 1'b1; done = 1'b1; end
      endcase
      if (tk) begin
        push_txn(pc, 1'b0, 8'h00); pc = m[pc]; nx = 2; lat = 3;
      end
      exp_cyc = exp_cyc + lat + nx * waits;
    end
    exp_pc = pc; exp_z = z; exp_c = c; exp_ill = ill;
    model_mem = m;
    model_ok = done;
  endtask

  task automatic start_run(input int mode, input int waits);
    rdy_mode  = mode;
    rdy_waits = waits;
    @(negedge clk); rst = 1'b0;
    load_pulse = 1'b1;
    @(negedge clk); load_pulse = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic finish_run(input string tag, input bit chk_cyc);
    int n = 0;
    int bad = 0;
    while (!halted && n < 5000) begin @(negedge clk); n++; end
    #1;
    if (!halted) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: halted still 0 after %0d cycles, required 1", tag, n);
      exp_q.delete();
      return;
    end
    repeat (3) @(negedge clk);
    check({tag, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    check({tag, "_pc"}, pc_out, exp_pc);
    check({tag, "_zflag"}, zflag, exp_z);
    check({tag, "_illegal"}, illegal_op, exp_ill);
    check({tag, "_req_idle"}, {halted, mem_req}, 2'b10);
`ifdef RISC_SPM_CARRY_EN
    check({tag, "_cflag"}, cflag, exp_c);
`endif
    if (chk_cyc) check({tag, "_cycles"}, halt_cyc, exp_cyc);
    for (int a = 0; a < 256; a++) if (mem[a] !== model_mem[a]) bad++;
    check({tag, "_mem_image"}, bad, 0);
  endtask

  task automatic clear_img();
    for (int a = 0; a < 256; a++) img[a] = 8'hF0;
  endtask

  task automatic gen_random();
    int p;
    int k;
    logic [3:0] op;
    for (int a = 0; a < 256; a++) img[a] = 8'($urandom_range(0, 255));
    p = 0;
    while (p < 'h60) begin
      k = $urandom_range(0, 31);
      if (k == 0)      op = 4'hF;
      else if (k == 1) op = 4'hC;
      else             op = 4'($urandom_range(0, 9));
      img[p] = {op, 4'($urandom_range(0, 15))};
      p++;
      if (op == 4'd5 || op == 4'd6) begin img[p] = 8'h80 + 8'($urandom_range(0, 63)); p++; end
      else if (op >= 4'd7 && op <= 4'd9) begin img[p] = 8'($urandom_range(0, 'h5F)); p++; end
    end
    img['h60] = 8'hF0;
  endtask

  initial begin
    int n;
    // reset values while rst is low
    #2;
    check("reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata, pc_out, zflag, halted, illegal_op},
          {2'b00, 8'h00, 8'h00, 8'h00, 3'b000});

    // RD R1 from 0x20, HALT
    clear_img();
    img[0] = 8'h51; img[1] = 8'h20; img['h20] = 8'h7F; img[2] = 8'hF0;
    model_run(0); start_run(0, 0); finish_run("rd_halt", 1'b1);
    check("rd_halt_cyc7", halt_cyc, 7);
    check("rd_halt_pc3", pc_out, 8'h03);

    // ADD wrapping to zero, taken BRZ, store of the result
    clear_img();
    img[0] = 8'h50; img[1] = 8'h20; img[2] = 8'h51; img[3] = 8'h21;
    img[4] = 8'h11; img[5] = 8'h80; img[6] = 8'h40;
    img['h20] = 8'h01; img['h21] = 8'hFF;
    img['h40] = 8'h64; img['h41] = 8'h90; img['h90] = 8'h55;
`ifdef RISC_SPM_CARRY_EN
    img['h42] = 8'h90; img['h43] = 8'h50;
`endif
    model_run(0); start_run(0, 0); finish_run("add_wrap", 1'b1);
    check("add_wrap_z", zflag, 1'b1);
    check("add_wrap_store", mem['h90], 8'h00);
`ifdef RISC_SPM_CARRY_EN
    check("brc_taken_pc", pc_out, 8'h51);
`endif

    // RD then WR of R2 with 3 wait states on every transfer
    clear_img();
    img[0] = 8'h52; img[1] = 8'h20; img['h20] = 8'hA5;
    img[2] = 8'h68; img[3] = 8'h30; img['h30] = 8'h00;
    model_run(3); start_run(0, 3); finish_run("wr_wait", 1'b1);
    check("wr_wait_data", mem['h30], 8'hA5);
    check("wr_wait_cyc", halt_cyc, 32);

    // BRZ not taken at 0x10, SUB R1,R1, BRZ taken to 0x80
    clear_img();
    img[0] = 8'h70; img[1] = 8'h10;
    img['h10] = 8'h80; img['h11] = 8'h80; img['h12] = 8'h25;
    img['h13] = 8'h80; img['h14] = 8'h80;
    model_run(0); start_run(0, 0); finish_run("brz", 1'b1);
    check("brz_pc", pc_out, 8'h81);
    check("brz_z", zflag, 1'b1);

    // illegal opcode trap, then flags clear on reset
    clear_img();
    img[0] = 8'hC0;
    model_run(0); start_run(0, 0); finish_run("illegal", 1'b1);
    check("illegal_flag", {illegal_op, halted}, 2'b11);
    check("illegal_cyc", halt_cyc, 3);
    @(negedge clk); rst = 1'b0; #1;
    check("illegal_clear", {illegal_op, halted}, 2'b00);

    // reset in the middle of a wait-stated write
    clear_img();
    img[0] = 8'h52; img[1] = 8'h20; img['h20] = 8'hA5;
    img[2] = 8'h68; img[3] = 8'h30; img['h30] = 8'h00;
    model_run(3); start_run(0, 3);
    n = 0;
    while (!(mem_req && mem_we && !mem_ready) && n < 200) begin @(negedge clk); n++; end
    check("midwr_reached", {mem_req, mem_we}, 2'b11);
    #2 rst = 1'b0;
    #1;
    check("midwr_reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata, pc_out, zflag, halted, illegal_op},
          {2'b00, 8'h00, 8'h00, 8'h00, 3'b000});
    repeat (2) @(negedge clk);
    check("midwr_no_write", mem['h30], 8'h00);
    exp_q.delete();
    clear_img();
    img[0] = 8'h51; img[1] = 8'h20; img['h20] = 8'h7F;
    model_run(0); start_run(0, 0); finish_run("restart", 1'b1);

    // randomized programs against the reference model
    for (int t = 0; t < 24; t++) begin
      int attempts = 0;
      int w;
      int md;
      md = (t % 3 == 0) ? 1 : 0;
      w  = (md == 1) ? 0 : $urandom_range(0, 2);
      do begin
        gen_random();
        model_run(w);
        attempts++;
      end while (!model_ok && attempts < 50);
      if (model_ok) begin
        start_run(md, w);
        finish_run("rand", md == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
